// File: rtl/shift_sequencer.sv
// shift_sequencer: round-robin front end for an external 8-bit barrel shifter.
// Accepts commands from two requesters with shift amounts 0..31, runs them as
// a series of shifter passes of at most STEP_MAX bits, and returns the result
// on a valid/ready response channel.
// Optional build macro SHIFT_SEQUENCER_STATS_EN adds per-requester saturating
// completed-response counters (stat_done0 / stat_done1).
module shift_sequencer #(
    parameter int STEP_MAX = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_data,
    input  logic [4:0]  req0_amt,
    input  logic [2:0]  req0_mode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_data,
    input  logic [4:0]  req1_amt,
    input  logic [2:0]  req1_mode,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_data,
    output logic        resp_id,
    output logic [7:0]  sh_i,
    output logic [3:0]  sh_n,
    output logic        sh_ar,
    output logic        sh_lr,
    output logic        sh_rot,
`ifdef SHIFT_SEQUENCER_STATS_EN
    output logic [15:0] stat_done0,
    output logic [15:0] stat_done1,
`endif
    input  logic [7:0]  sh_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] STEP_N = 4'(STEP_MAX);

    // mode bit positions: {ar, lr, rot}
    localparam int M_AR  = 2;
    localparam int M_LR  = 1;
    localparam int M_ROT = 0;

    logic [1:0] state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] rem_q, rem_d;
    logic [2:0] mode_q, mode_d;
    logic       id_q, id_d;
    logic       rr_q, rr_d;      // requester favoured when both are valid

    logic       gnt_valid_s;
    logic       gnt_id_s;
    logic [7:0] sel_data_s;
    logic [4:0] sel_amt_s;
    logic [2:0] sel_mode_s;
    logic [3:0] sel_eff_s;
    logic [3:0] pass_n_s;
    logic [3:0] rem_next_s;
    logic       resp_fire_s;

    // Effective amount: rotations wrap mod 8, plain shifts clamp at a full flush.
    function automatic logic [3:0] eff_amt(input logic [4:0] amt, input logic [2:0] mode);
        logic [3:0] e;
        if (mode[M_ROT]) begin
            e = {1'b0, amt[2:0]};
        end else if (amt >= 5'd8) begin
            e = 4'd8;
        end else begin
            e = amt[3:0];
        end
        return e;
    endfunction

    // Arbitration: grant only in IDLE; ties go to the requester not served last.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = rr_q;
            end else if (req0_valid) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = 1'b0;
            end else if (req1_valid) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = 1'b1;
            end else begin
                gnt_valid_s = 1'b0;
                gnt_id_s    = 1'b0;
            end
        end else begin
            gnt_valid_s = 1'b0;
            gnt_id_s    = 1'b0;
        end
    end

    assign req0_ready = gnt_valid_s && !gnt_id_s;
    assign req1_ready = gnt_valid_s &&  gnt_id_s;

    assign sel_data_s = gnt_id_s ? req1_data : req0_data;
    assign sel_amt_s  = gnt_id_s ? req1_amt  : req0_amt;
    assign sel_mode_s = gnt_id_s ? req1_mode : req0_mode;
    assign sel_eff_s  = eff_amt(sel_amt_s, sel_mode_s);

    // Per-pass amount is the remaining distance capped at STEP_MAX.
    assign pass_n_s   = (rem_q > STEP_N) ? STEP_N : rem_q;
    assign rem_next_s = rem_q - pass_n_s;

    assign resp_fire_s = (state_q == ST_DONE) && resp_ready;

    // Next-state logic for the sequencer FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        id_d    = id_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    acc_d   = sel_data_s;
                    mode_d  = sel_mode_s;
                    id_d    = gnt_id_s;
                    rr_d    = ~gnt_id_s;
                    rem_d   = sel_eff_s;
                    state_d = (sel_eff_s == 4'd0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = sh_o;
                rem_d   = rem_next_s;
                state_d = (rem_next_s == 4'd0) ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            acc_q   <= 8'h00;
            rem_q   <= 4'd0;
            mode_q  <= 3'b000;
            id_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end

    // Shifter is idle (sh_n = 0) outside RUN, so its output is harmless.
    assign sh_i   = acc_q;
    assign sh_n   = (state_q == ST_RUN) ? pass_n_s : 4'd0;
    assign sh_ar  = mode_q[M_AR];
    assign sh_lr  = mode_q[M_LR];
    assign sh_rot = mode_q[M_ROT];

    assign resp_valid = (state_q == ST_DONE);
    assign resp_data  = acc_q;
    assign resp_id    = id_q;

`ifdef SHIFT_SEQUENCER_STATS_EN
    logic [15:0] done0_q;
    logic [15:0] done1_q;

    // Saturating count of completed response handshakes per requester.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            done0_q <= 16'h0000;
            done1_q <= 16'h0000;
        end else if (resp_fire_s) begin
            if (!id_q && (done0_q != 16'hFFFF)) begin
                done0_q <= done0_q + 16'h0001;
            end else if (id_q && (done1_q != 16'hFFFF)) begin
                done1_q <= done1_q + 16'h0001;
            end else begin
                done0_q <= done0_q;
                done1_q <= done1_q;
            end
        end else begin
            done0_q <= done0_q;
            done1_q <= done1_q;
        end
    end

    assign stat_done0 = done0_q;
    assign stat_done1 = done1_q;
`else
    logic unused_fire_s;
    assign unused_fire_s = resp_fire_s;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer (STEP_MAX = 4) with a behavioural
// model of the external 8-bit barrel shifter.
module tb_shift_sequencer;

    logic        clk;
    logic        nrst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_data, req1_data;
    logic [4:0]  req0_amt, req1_amt;
    logic [2:0]  req0_mode, req1_mode;
    logic        resp_valid, resp_ready;
    logic [7:0]  resp_data;
    logic        resp_id;
    logic [7:0]  sh_i;
    logic [3:0]  sh_n;
    logic        sh_ar, sh_lr, sh_rot;
    logic [7:0]  sh_o;
`ifdef SHIFT_SEQUENCER_STATS_EN
    logic [15:0] stat_done0, stat_done1;
`endif

    int checks   = 0;
    int failures = 0;

    shift_sequencer #(.STEP_MAX(4)) dut (
        .clk(clk), .nrst(nrst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_mode(req1_mode),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id),
        .sh_i(sh_i), .sh_n(sh_n), .sh_ar(sh_ar), .sh_lr(sh_lr), .sh_rot(sh_rot),
`ifdef SHIFT_SEQUENCER_STATS_EN
        .stat_done0(stat_done0), .stat_done1(stat_done1),
`endif
        .sh_o(sh_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External barrel shifter: n in 0..8, rot over ar, lr=1 left.
    function automatic logic [7:0] shf(input logic [7:0] i, input logic [3:0] n,
                                       input logic ar, input logic lr, input logic rot);
        logic [7:0] t;
        logic [3:0] r;
        r = {1'b0, n[2:0]};
        if (rot) begin
            if (lr) t = (i << r) | (i >> (4'd8 - r));
            else    t = (i >> r) | (i << (4'd8 - r));
        end else if (lr) begin
            t = i << n;
        end else if (ar) begin
            t = $signed(i) >>> n;
        end else begin
            t = i >> n;
        end
        return t;
    endfunction

    always_comb sh_o = shf(sh_i, sh_n, sh_ar, sh_lr, sh_rot);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Present one command at a negedge, confirm the grant, release after the accept edge.
    task automatic send(input logic id, input logic [7:0] d, input logic [4:0] a,
                        input logic [2:0] m);
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_mode = m;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_mode = m;
        end
        #1;
        chk("grant_ready0", {15'd0, req0_ready}, {15'd0, !id});
        chk("grant_ready1", {15'd0, req1_ready}, {15'd0, id});
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Called right after the accept edge: checks pass amounts, latency and result.
    task automatic expect_resp(input int passes, input logic [3:0] n0, input logic [3:0] n1,
                               input logic [7:0] ed, input logic eid);
        int cyc;
        int k;
        logic [3:0] en;
        k = 0;
        @(negedge clk);
        cyc = 1;
        while (!resp_valid && cyc < 40) begin
            en = (k == 0) ? n0 : ((k == 1) ? n1 : 4'd0);
            chk("pass_sh_n", {12'd0, sh_n}, {12'd0, en});
            k++;
            @(negedge clk);
            cyc++;
        end
        chk("resp_valid_timeout", {15'd0, resp_valid}, 16'd1);
        chk("resp_latency", 16'(cyc), 16'(passes + 1));
        chk("resp_data", {8'd0, resp_data}, {8'd0, ed});
        chk("resp_id", {15'd0, resp_id}, {15'd0, eid});
        chk("sh_n_idle_in_done", {12'd0, sh_n}, 16'd0);
    endtask

    task automatic consume();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("resp_valid_after_hs", {15'd0, resp_valid}, 16'd0);
    endtask

    initial begin
        nrst = 1'b0;
        req0_valid = 1'b0; req0_data = 8'h00; req0_amt = 5'd0; req0_mode = 3'b000;
        req1_valid = 1'b0; req1_data = 8'h00; req1_amt = 5'd0; req1_mode = 3'b000;
        resp_ready = 1'b0;
        #1;
        chk("rst_resp_valid", {15'd0, resp_valid}, 16'd0);
        chk("rst_resp_data", {8'd0, resp_data}, 16'd0);
        chk("rst_sh_bus", {4'd0, sh_i, sh_ar, sh_lr, sh_rot, resp_id}, 16'd0);
        chk("rst_sh_n", {12'd0, sh_n}, 16'd0);
        chk("rst_ready", {14'd0, req0_ready, req1_ready}, 16'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Logical right 6: passes 4 then 2, 0xF0 -> 0x03.
        send(1'b0, 8'hF0, 5'd6, 3'b000);
        expect_resp(2, 4'd4, 4'd2, 8'h03, 1'b0);
        consume();

        // Arithmetic right 12 clamps to 8: passes 4,4, sign fill 0xFF.
        send(1'b1, 8'h90, 5'd12, 3'b100);
        expect_resp(2, 4'd4, 4'd4, 8'hFF, 1'b1);

        // Backpressure with a pending req0 command.
        req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 5'd9; req0_mode = 3'b001;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", {15'd0, resp_valid}, 16'd1);
            chk("bp_data", {8'd0, resp_data}, 16'h00FF);
            chk("bp_id", {15'd0, resp_id}, 16'd1);
            chk("bp_ready", {14'd0, req0_ready, req1_ready}, 16'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("bp_idle_valid", {15'd0, resp_valid}, 16'd0);
        chk("bp_idle_ready0", {15'd0, req0_ready}, 16'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        // Rotate right 9 -> eff 1: 0x81 -> 0xC0.
        expect_resp(1, 4'd1, 4'd0, 8'hC0, 1'b0);
        consume();

        // Rotate left 8 -> eff 0: result at T+1, shifter never stepped.
        send(1'b0, 8'h81, 5'd8, 3'b011);
        expect_resp(0, 4'd0, 4'd0, 8'h81, 1'b0);
        consume();

`ifdef SHIFT_SEQUENCER_STATS_EN
        chk("stat0_count", stat_done0, 16'd3);
        chk("stat1_count", stat_done1, 16'd1);
`endif

        // Asynchronous reset during RUN drops the command.
        send(1'b1, 8'hAA, 5'd20, 3'b000);
        @(negedge clk);
        chk("run_before_rst", {12'd0, sh_n}, 16'd4);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_resp_valid", {15'd0, resp_valid}, 16'd0);
        chk("arst_sh_bus", {4'd0, sh_i, sh_ar, sh_lr, sh_rot, resp_id}, 16'd0);
        chk("arst_sh_n", {12'd0, sh_n}, 16'd0);
        chk("arst_resp_data", {8'd0, resp_data}, 16'd0);
`ifdef SHIFT_SEQUENCER_STATS_EN
        chk("arst_stats", stat_done0 | stat_done1, 16'd0);
`endif
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_resp_after_rst", {15'd0, resp_valid}, 16'd0);
        end

        // Both requesters valid: grants alternate 0,1,0,1.
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'h0F; req0_amt = 5'd3; req0_mode = 3'b010;
        req1_valid = 1'b1; req1_data = 8'h01; req1_amt = 5'd3; req1_mode = 3'b010;
        for (int g = 0; g < 4; g++) begin
            logic gid;
            gid = g[0];
            #1;
            chk("rr_ready0", {15'd0, req0_ready}, {15'd0, !gid});
            chk("rr_ready1", {15'd0, req1_ready}, {15'd0, gid});
            @(posedge clk);
            #1;
            expect_resp(1, 4'd3, 4'd0, gid ? 8'h08 : 8'h78, gid);
            consume();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`ifdef SHIFT_SEQUENCER_STATS_EN
        chk("stat0_after_rr", stat_done0, 16'd2);
        chk("stat1_after_rr", stat_done1, 16'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
